// File: rtl/npu_pkg.sv
// Shared types for the NPU command path: command codes, tile request kinds
// and the queued command entry.
package npu_pkg;

    localparam logic [7:0] CMD_WRITE    = 8'h01;
    localparam logic [7:0] CMD_EXEC     = 8'h02;
    localparam logic [7:0] CMD_READ     = 8'h03;
    localparam logic [7:0] DATA_TIMEOUT = 8'hEE;

    typedef enum logic [1:0] {
        KIND_WRITE = 2'd0,
        KIND_EXEC  = 2'd1,
        KIND_READ  = 2'd2
    } tile_kind_t;

    typedef struct packed {
        tile_kind_t  kind;
        logic [5:0]  addr;
        logic [2:0]  opcode;
        logic [7:0]  wdata;
    } npu_cmd_t;

endpackage

// File: rtl/npu_cmd_fifo.sv
// Synchronous FIFO of decoded NPU commands. A push is accepted when the FIFO is
// not full, or when a pop frees a slot in the same cycle.
module npu_cmd_fifo
    import npu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  npu_cmd_t                      din_i,
    input  logic                          pop_i,
    output npu_cmd_t                      dout_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    npu_cmd_t        mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/npu_cmd_scheduler.sv
// Queues decoded SPI commands and dispatches them one at a time to the 8x8 tile
// array over req/ack, with an ack timeout, READ data return and sticky errors.
module npu_cmd_scheduler
    import npu_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd,
    input  logic [2:0] tile_i,
    input  logic [2:0] tile_j,
    input  logic [2:0] op_code,
    input  logic [7:0] data_in,
    input  logic       clear_err,
    output logic       tile_req,
    output logic [5:0] tile_addr,
    output logic [1:0] tile_kind,
    output logic [2:0] tile_opcode,
    output logic [7:0] tile_wdata,
    input  logic       tile_ack,
    input  logic [7:0] tile_rdata,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       err_overflow,
    output logic       err_badcmd,
    output logic       err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    npu_cmd_t                     issue_q, issue_d;
    logic [7:0]                   data_q, data_d;
    logic                         err_ovf_q, err_bad_q, err_to_q;
    logic                         legal, pop, timeout_evt;
    npu_cmd_t                     new_cmd, fifo_dout;
    logic                         fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;

    always_comb begin
        legal        = 1'b1;
        new_cmd.kind = KIND_WRITE;
        case (cmd)
            CMD_WRITE: new_cmd.kind = KIND_WRITE;
            CMD_EXEC:  new_cmd.kind = KIND_EXEC;
            CMD_READ:  new_cmd.kind = KIND_READ;
            default:   legal        = 1'b0;
        endcase
        new_cmd.addr   = {tile_i, tile_j};
        new_cmd.opcode = op_code;
        new_cmd.wdata  = data_in;
    end

    npu_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_valid && legal),
        .din_i   (new_cmd),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        issue_d     = issue_q;
        data_d      = data_q;
        pop         = 1'b0;
        timeout_evt = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    issue_d = fifo_dout;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // An ack in the final allowed cycle still counts as success.
                if (tile_ack) begin
                    state_d = S_DONE;
                    if (issue_q.kind == KIND_READ) data_d = tile_rdata;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d     = S_DONE;
                    timeout_evt = 1'b1;
                    data_d      = DATA_TIMEOUT;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            issue_q   <= '0;
            data_q    <= '0;
            err_ovf_q <= 1'b0;
            err_bad_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            issue_q   <= issue_d;
            data_q    <= data_d;
            err_ovf_q <= (cmd_valid && legal && fifo_full && !pop) || (err_ovf_q && !clear_err);
            err_bad_q <= (cmd_valid && !legal) || (err_bad_q && !clear_err);
            err_to_q  <= timeout_evt || (err_to_q && !clear_err);
        end
    end

    assign tile_req     = (state_q == S_ISSUE);
    assign tile_addr    = issue_q.addr;
    assign tile_kind    = issue_q.kind;
    assign tile_opcode  = issue_q.opcode;
    assign tile_wdata   = issue_q.wdata;
    assign data_out     = data_q;
    assign busy         = (fifo_count != '0) || (state_q != S_IDLE);
    assign err_overflow = err_ovf_q;
    assign err_badcmd   = err_bad_q;
    assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_npu_cmd_scheduler.sv
// Directed bench for npu_cmd_scheduler with hand-computed expectations.
module tb_npu_cmd_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd = '0;
    logic [2:0] tile_i = '0, tile_j = '0, op_code = '0;
    logic [7:0] data_in = '0;
    logic       clear_err = 1'b0;
    logic       tile_req;
    logic [5:0] tile_addr;
    logic [1:0] tile_kind;
    logic [2:0] tile_opcode;
    logic [7:0] tile_wdata;
    logic       tile_ack = 1'b0;
    logic [7:0] tile_rdata = '0;
    logic [7:0] data_out;
    logic       busy, err_overflow, err_badcmd, err_timeout;

    int n_vec = 0;
    int n_err = 0;

    npu_cmd_scheduler #(.FIFO_DEPTH(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd),
        .tile_i(tile_i), .tile_j(tile_j), .op_code(op_code), .data_in(data_in),
        .clear_err(clear_err), .tile_req(tile_req), .tile_addr(tile_addr),
        .tile_kind(tile_kind), .tile_opcode(tile_opcode), .tile_wdata(tile_wdata),
        .tile_ack(tile_ack), .tile_rdata(tile_rdata), .data_out(data_out),
        .busy(busy), .err_overflow(err_overflow), .err_badcmd(err_badcmd),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [2:0] ti, input logic [2:0] tj,
                        input logic [2:0] op, input logic [7:0] d);
        cmd_valid = 1'b1; cmd = c; tile_i = ti; tile_j = tj; op_code = op; data_in = d;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req(input int max_cyc);
        int n = 0;
        while (!tile_req && n < max_cyc) begin
            step();
            n++;
        end
        chk("req_rise", {31'd0, tile_req}, 32'd1);
    endtask

    task automatic ack_once(input logic [7:0] rd);
        tile_ack = 1'b1; tile_rdata = rd;
        step();
        tile_ack = 1'b0;
    endtask

    initial begin
        int n;
        #2;
        chk("rst_req", {31'd0, tile_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dout", {24'd0, data_out}, 32'd0);
        chk("rst_errs", {29'd0, err_overflow, err_badcmd, err_timeout}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // WRITE to (2,5): request in cycle N+2, ack in its third cycle
        send(8'h01, 3'd2, 3'd5, 3'd0, 8'h3C);
        chk("wr_req_n1", {31'd0, tile_req}, 32'd0);
        step();
        chk("wr_req_n2", {31'd0, tile_req}, 32'd1);
        chk("wr_addr", {26'd0, tile_addr}, 32'h15);
        chk("wr_kind", {30'd0, tile_kind}, 32'd0);
        chk("wr_wdata", {24'd0, tile_wdata}, 32'h3C);
        step(); step();
        chk("wr_req_hold", {31'd0, tile_req}, 32'd1);
        ack_once(8'hA5);
        chk("wr_req_done", {31'd0, tile_req}, 32'd0);
        chk("wr_dout", {24'd0, data_out}, 32'd0);
        step();

        // READ from (7,7)
        send(8'h03, 3'd7, 3'd7, 3'd0, 8'h00);
        step();
        chk("rd_req", {31'd0, tile_req}, 32'd1);
        chk("rd_addr", {26'd0, tile_addr}, 32'h3F);
        chk("rd_kind", {30'd0, tile_kind}, 32'd2);
        ack_once(8'h9A);
        chk("rd_dout", {24'd0, data_out}, 32'h9A);
        chk("rd_busy_done", {31'd0, busy}, 32'd1);
        step();
        chk("rd_busy_idle", {31'd0, busy}, 32'd0);

        // EXEC forwards op_code
        send(8'h02, 3'd3, 3'd1, 3'd6, 8'h00);
        step();
        chk("ex_kind", {30'd0, tile_kind}, 32'd1);
        chk("ex_op", {29'd0, tile_opcode}, 32'd6);
        ack_once(8'h77);
        chk("ex_dout", {24'd0, data_out}, 32'h9A);
        step();

        // Timeout: never ack, request high exactly 16 cycles
        send(8'h03, 3'd1, 3'd1, 3'd0, 8'h00);
        step();
        n = 0;
        while (tile_req && n < 40) begin
            n++;
            step();
        end
        chk("to_len", n, 32'd16);
        chk("to_flag", {31'd0, err_timeout}, 32'd1);
        chk("to_dout", {24'd0, data_out}, 32'hEE);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("to_clear", {31'd0, err_timeout}, 32'd0);
        step();

        // Ack in the 16th request cycle wins over the timeout
        send(8'h03, 3'd4, 3'd2, 3'd0, 8'h00);
        step();
        for (int k = 0; k < 15; k++) step();
        chk("lim_req", {31'd0, tile_req}, 32'd1);
        ack_once(8'h5A);
        chk("lim_noerr", {31'd0, err_timeout}, 32'd0);
        chk("lim_dout", {24'd0, data_out}, 32'h5A);
        step();

        // Ack without a request is ignored
        ack_once(8'h11);
        chk("stray_dout", {24'd0, data_out}, 32'h5A);
        chk("stray_busy", {31'd0, busy}, 32'd0);

        // Bad command code
        send(8'h7F, 3'd1, 3'd2, 3'd0, 8'h00);
        chk("bad_flag", {31'd0, err_badcmd}, 32'd1);
        chk("bad_busy", {31'd0, busy}, 32'd0);
        step();
        chk("bad_noreq", {31'd0, tile_req}, 32'd0);
        clear_err = 1'b1;
        send(8'h7F, 3'd1, 3'd2, 3'd0, 8'h00);
        chk("bad_setwins", {31'd0, err_badcmd}, 32'd1);
        send(8'h00, 3'd0, 3'd0, 3'd0, 8'h00);
        chk("bad_setwins0", {31'd0, err_badcmd}, 32'd1);
        cmd_valid = 1'b0;
        step();
        clear_err = 1'b0;
        chk("bad_clear", {31'd0, err_badcmd}, 32'd0);

        // Overflow: six back-to-back WRITEs with ack held low
        for (int k = 0; k < 6; k++) send(8'h01, 3'd0, 3'(k + 1), 3'd0, 8'(8'h10 + k));
        chk("ovf_flag", {31'd0, err_overflow}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            wait_req(10);
            chk($sformatf("ovf_addr%0d", k), {26'd0, tile_addr}, 32'(k + 1));
            chk($sformatf("ovf_wd%0d", k), {24'd0, tile_wdata}, 32'(8'h10 + k));
            ack_once(8'h00);
        end
        n = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (tile_req) n++;
        end
        chk("ovf_dropped", n, 32'd0);
        chk("ovf_busy", {31'd0, busy}, 32'd0);

        // Reset while a request is outstanding and two entries are queued
        send(8'h01, 3'd1, 3'd1, 3'd0, 8'h01);
        send(8'h01, 3'd1, 3'd2, 3'd0, 8'h02);
        send(8'h01, 3'd1, 3'd3, 3'd0, 8'h03);
        chk("mrst_pre", {31'd0, tile_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_req", {31'd0, tile_req}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_ovf", {31'd0, err_overflow}, 32'd0);
        chk("mrst_addr", {26'd0, tile_addr}, 32'd0);
        step();
        #2 rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (tile_req || busy) n++;
        end
        chk("mrst_after", n, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/npu_cmd_scheduler.md
Name: npu_cmd_scheduler

Overview:
- Sits in the `clk` domain between the SPI command front end and the 8x8 NPU tile array.
- Accepts decoded command pulses (`cmd`, `tile_i`, `tile_j`, `op_code`, `data_in`, `valid`) and buffers them in a small FIFO.
- Dispatches one command at a time to the addressed tile over a req/ack handshake, with a timeout on the ack.
- Returns READ results on `data_out` for the SPI MISO path and keeps sticky error flags.

Parameters:
- `FIFO_DEPTH`, 4, number of queued commands; power of two, ≥2.
- `TIMEOUT_CYC`, 16, clk cycles `tile_req` may stay high without `tile_ack` before the command is aborted.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  one-cycle pulse; command fields are valid this cycle.
- `cmd`  in  8  command code: 0x01 WRITE, 0x02 EXEC, 0x03 READ.
- `tile_i`  in  3  tile row.
- `tile_j`  in  3  tile column.
- `op_code`  in  3  EXEC operation.
- `data_in`  in  8  WRITE payload.
- `clear_err`  in  1  clears all sticky error flags.
- `tile_req`  out  1  request to the tile array.
- `tile_addr`  out  6  {`tile_i`, `tile_j`}.
- `tile_kind`  out  2  0 WRITE, 1 EXEC, 2 READ.
- `tile_opcode`  out  3  forwarded `op_code`.
- `tile_wdata`  out  8  forwarded `data_in`.
- `tile_ack`  in  1  tile accepted/completed the request; sampled only while `tile_req`=1.
- `tile_rdata`  in  8  READ data; valid with `tile_ack`.
- `data_out`  out  8  last READ result, or 0xEE after a timeout.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.
- `err_overflow`  out  1  sticky: a command was dropped because the FIFO was full.
- `err_badcmd`  out  1  sticky: an unknown `cmd` code was dropped.
- `err_timeout`  out  1  sticky: a request timed out.

Behaviour:
- **Reset.** All outputs 0, FIFO empty, FSM in IDLE, timeout counter 0. Assertion mid-transfer drops `tile_req` immediately and discards queued commands.
- **Enqueue.**
  - On `cmd_valid`, when `cmd` is a legal code and the FIFO is not full (or a pop happens the same cycle), the entry {kind, addr, opcode, wdata} is written at the clock edge.
  - Unknown code: entry is not written; `err_badcmd` is set. No backpressure exists toward the SPI side.
  - Full FIFO and no pop that cycle: entry is dropped; `err_overflow` is set.
- **FSM states:** IDLE, ISSUE, DONE.
  - IDLE → ISSUE when the FIFO is non-empty. The head is popped into the issue registers on this transition.
  - ISSUE: `tile_req`=1 with address and fields held stable. The timeout counter increments each cycle.
    - `tile_ack` → DONE.
    - Counter reaches `TIMEOUT_CYC` → DONE; `err_timeout` is set and `data_out` = 0xEE.
  - DONE: `tile_req`=0 for exactly one cycle, counter cleared, → IDLE.
- **Latency.** With the block idle and the FIFO empty, `cmd_valid` in cycle N gives `tile_req` high in cycle N+2. Back-to-back requests are separated by at least 2 cycles with `tile_req` low (DONE, IDLE).
- **Ack handling.** READ ack: `data_out` ← `tile_rdata` on the ack edge. WRITE/EXEC ack: `data_out` is unchanged.
  - Ack arriving in the same cycle the counter hits `TIMEOUT_CYC`: the ack wins and no error is raised.
  - `tile_ack` while `tile_req`=0 is ignored.
- **Error flags.** Each flag stays set until `clear_err`.
  - If `clear_err` coincides with a new error event, the set wins.
- **FIFO storage.** Pointers wrap modulo `FIFO_DEPTH`. Count is `$clog2(FIFO_DEPTH)+1` bits. Full when count = `FIFO_DEPTH`.
- **Status.** `busy` is combinational from the FIFO count and FSM state.

Decomposition:
- Shared package `npu_pkg` holds:
  - command codes `CMD_WRITE`/`CMD_EXEC`/`CMD_READ`;
  - `tile_kind_t` enum;
  - `DATA_TIMEOUT` = 8'hEE;
  - packed struct `npu_cmd_t` {kind, addr, opcode, wdata}.
- One sub-module, `npu_cmd_fifo`: synchronous FIFO of `npu_cmd_t` with push, pop, full, empty and count. Same `clk`/`rst_n` as the scheduler.

Test Plan:
- **WRITE.** `cmd`=0x01, tile (2,5), `data_in`=0x3C, ack after 3 cycles. Expect `tile_req` at N+2, `tile_addr`=6'b010101, `tile_kind`=0, `tile_wdata`=0x3C; `tile_req` low one cycle after ack; `data_out` unchanged.
- **READ.** `cmd`=0x03, tile (7,7), ack with `tile_rdata`=0x9A. Expect `data_out`=0x9A and `busy`=0 two cycles after ack.
- **Overflow.** Hold `tile_ack`=0, send 6 commands 1 cycle apart. Expect the first issued, next 4 queued, 6th dropped, `err_overflow`=1; all 5 kept commands later issue in order.
- **Timeout.** `TIMEOUT_CYC`=16, never ack. Expect `tile_req` high exactly 16 cycles, `err_timeout`=1, `data_out`=0xEE; `clear_err` then clears the flag.
- **Bad command.** `cmd`=0x7F. Expect no `tile_req`, `err_badcmd`=1, FIFO count stays 0.
- **Reset mid-ISSUE.** `rst_n`=0 while `tile_req`=1 with 2 entries queued. Expect `tile_req`=0 asynchronously, `busy`=0, and no request after reset release.
